// File: rtl/pc_sequencer.sv
// Fetch-address generator: architectural PC, EPC and a BOOT/RUN/HALT sequencer.
// Optional build macro PC_MISALIGN_TRAP_EN: misaligned branch targets trap instead of being masked.
module pc_sequencer #(
  parameter int unsigned XLEN         = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned STEP         = 4
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_fetch_ready,
  input  logic            i_pc_sel,
  input  logic [XLEN-1:0] i_wb,
  input  logic            i_trap,
  input  logic [XLEN-1:0] i_trap_pc,
  input  logic            i_mret,
  input  logic            i_halt,
  input  logic            i_resume,
  output logic [XLEN-1:0] o_pc,
  output logic            o_pc_valid,
  output logic [XLEN-1:0] o_pc_step,
  output logic [XLEN-1:0] o_epc,
  output logic            o_redirect,
  output logic            o_halted,
  output logic            o_misalign
);

  localparam logic [XLEN-1:0] ResetPc   = XLEN'(RESET_VECTOR);
  localparam logic [XLEN-1:0] TrapPc    = XLEN'(TRAP_VECTOR);
  localparam logic [XLEN-1:0] StepInc   = XLEN'(STEP);
  // Low bits that must be zero for an aligned fetch target (empty mask when STEP == 1).
  localparam logic [XLEN-1:0] AlignMask = XLEN'(STEP - 1);

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StHalt
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            redirect_q, redirect_d;
  logic            misalign_q, misalign_d;
  logic            accept;

  assign accept    = (state_q == StRun) && i_fetch_ready;
  assign o_pc_step = pc_q + StepInc;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    epc_d      = epc_q;
    redirect_d = 1'b0;
    misalign_d = 1'b0;

    unique case (state_q)
      StBoot:  state_d = StRun;
      StRun:   if (i_halt) state_d = StHalt;
      StHalt:  if (i_resume) state_d = StRun;
      default: state_d = StBoot;
    endcase

    // BOOT ignores every request; redirects apply in both RUN and HALT.
    if (state_q != StBoot) begin
      if (i_trap) begin
        epc_d      = i_trap_pc;
        pc_d       = TrapPc;
        redirect_d = 1'b1;
      end else if (i_mret) begin
        pc_d       = epc_q;
        redirect_d = 1'b1;
      end else if (i_pc_sel) begin
        redirect_d = 1'b1;
`ifdef PC_MISALIGN_TRAP_EN
        if ((i_wb & AlignMask) != '0) begin
          epc_d      = pc_q;
          pc_d       = TrapPc;
          misalign_d = 1'b1;
        end else begin
          pc_d = i_wb;
        end
`else
        pc_d = i_wb & ~AlignMask;
`endif
      end else if (accept) begin
        pc_d = o_pc_step;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= StBoot;
      pc_q       <= ResetPc;
      epc_q      <= '0;
      redirect_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      redirect_q <= redirect_d;
      misalign_q <= misalign_d;
    end
  end

  assign o_pc       = pc_q;
  assign o_epc      = epc_q;
  assign o_pc_valid = (state_q == StRun);
  assign o_halted   = (state_q == StHalt);
  assign o_redirect = redirect_q;
  assign o_misalign = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, reset corner case, random vs model.
module tb_pc_sequencer;

`ifdef PC_MISALIGN_TRAP_EN
  localparam bit MisTrap = 1'b1;
`else
  localparam bit MisTrap = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_ready, pc_sel, trap, mret, halt, resume;
  logic [31:0] wb, trap_pc;
  logic [31:0] pc, pc_step, epc;
  logic        pc_valid, redirect, halted, misalign;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_fetch_ready(fetch_ready),
    .i_pc_sel     (pc_sel),
    .i_wb         (wb),
    .i_trap       (trap),
    .i_trap_pc    (trap_pc),
    .i_mret       (mret),
    .i_halt       (halt),
    .i_resume     (resume),
    .o_pc         (pc),
    .o_pc_valid   (pc_valid),
    .o_pc_step    (pc_step),
    .o_epc        (epc),
    .o_redirect   (redirect),
    .o_halted     (halted),
    .o_misalign   (misalign)
  );

  typedef struct {
    logic        rdy;
    logic        sel;
    logic [31:0] wb;
    logic        trap;
    logic [31:0] tpc;
    logic        mret;
    logic        halt;
    logic        resume;
    logic [31:0] pc;
    logic [31:0] epc;
    logic        valid;
    logic        redir;
    logic        halted;
    logic        mis;
  } vec_t;

  vec_t vecs[$];

  // Reference model state, kept in terms of the architectural rules.
  localparam int MBoot = 0, MRun = 1, MHalt = 2;
  int          m_mode;
  logic [31:0] m_pc, m_epc;
  logic        m_redir, m_mis;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_epc,
                         input logic e_valid, input logic e_redir, input logic e_halted,
                         input logic e_mis);
    chk({tag, " pc"}, pc, e_pc);
    chk({tag, " pc_step"}, pc_step, e_pc + 32'd4);
    chk({tag, " epc"}, epc, e_epc);
    chk({tag, " valid"}, {31'd0, pc_valid}, {31'd0, e_valid});
    chk({tag, " redirect"}, {31'd0, redirect}, {31'd0, e_redir});
    chk({tag, " halted"}, {31'd0, halted}, {31'd0, e_halted});
    chk({tag, " misalign"}, {31'd0, misalign}, {31'd0, e_mis});
  endtask

  task automatic drive(input logic r, input logic s, input logic [31:0] w, input logic t,
                       input logic [31:0] tp, input logic m, input logic h, input logic re);
    fetch_ready = r; pc_sel = s; wb = w; trap = t; trap_pc = tp; mret = m; halt = h; resume = re;
  endtask

  task automatic add(input logic r, input logic s, input logic [31:0] w, input logic t,
                     input logic [31:0] tp, input logic m, input logic h, input logic re,
                     input logic [31:0] e_pc, input logic [31:0] e_epc, input logic e_valid,
                     input logic e_redir, input logic e_halted, input logic e_mis);
    vec_t v;
    v.rdy = r; v.sel = s; v.wb = w; v.trap = t; v.tpc = tp; v.mret = m; v.halt = h;
    v.resume = re; v.pc = e_pc; v.epc = e_epc; v.valid = e_valid; v.redir = e_redir;
    v.halted = e_halted; v.mis = e_mis;
    vecs.push_back(v);
  endtask

  task automatic model_reset();
    m_mode = MBoot; m_pc = 32'h0; m_epc = 32'h0; m_redir = 1'b0; m_mis = 1'b0;
  endtask

  task automatic model_edge();
    logic [31:0] n_pc, n_epc;
    int          n_mode;
    n_pc = m_pc; n_epc = m_epc; n_mode = m_mode;
    m_redir = 1'b0; m_mis = 1'b0;
    if (m_mode == MBoot) begin
      n_mode = MRun;
    end else begin
      if (trap) begin
        n_epc = trap_pc; n_pc = 32'h100; m_redir = 1'b1;
      end else if (mret) begin
        n_pc = m_epc; m_redir = 1'b1;
      end else if (pc_sel) begin
        m_redir = 1'b1;
        if (MisTrap && (wb % 4 != 0)) begin
          n_epc = m_pc; n_pc = 32'h100; m_mis = 1'b1;
        end else begin
          n_pc = wb - (wb % 4);
        end
      end else if (m_mode == MRun && fetch_ready) begin
        n_pc = m_pc + 32'd4;
      end
      if (m_mode == MRun && halt) n_mode = MHalt;
      else if (m_mode == MHalt && resume) n_mode = MRun;
    end
    m_pc = n_pc; m_epc = n_epc; m_mode = n_mode;
  endtask

  initial begin
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;

    //   rdy sel wb            trap tpc    mret halt res  pc            epc    vld red hlt mis
    add(1, 0, 32'h0,          0, 32'h0,  0, 0, 0, 32'h0,          32'h0,  1, 0, 0, 0);
    add(1, 0, 32'h0,          0, 32'h0,  0, 0, 0, 32'h4,          32'h0,  1, 0, 0, 0);
    add(1, 0, 32'h0,          0, 32'h0,  0, 0, 0, 32'h8,          32'h0,  1, 0, 0, 0);
    add(1, 0, 32'h0,          0, 32'h0,  0, 0, 0, 32'hC,          32'h0,  1, 0, 0, 0);
    add(1, 0, 32'h0,          0, 32'h0,  0, 0, 0, 32'h10,         32'h0,  1, 0, 0, 0);
    add(0, 0, 32'h0,          0, 32'h0,  0, 0, 0, 32'h10,         32'h0,  1, 0, 0, 0);
    add(0, 0, 32'h0,          0, 32'h0,  0, 0, 0, 32'h10,         32'h0,  1, 0, 0, 0);
    add(0, 0, 32'h0,          0, 32'h0,  0, 0, 0, 32'h10,         32'h0,  1, 0, 0, 0);
    add(1, 0, 32'h0,          0, 32'h0,  0, 0, 0, 32'h14,         32'h0,  1, 0, 0, 0);
    add(1, 0, 32'h0,          0, 32'h0,  0, 0, 0, 32'h18,         32'h0,  1, 0, 0, 0);
    add(1, 0, 32'h0,          0, 32'h0,  0, 0, 0, 32'h1C,         32'h0,  1, 0, 0, 0);
    add(1, 0, 32'h0,          0, 32'h0,  0, 0, 0, 32'h20,         32'h0,  1, 0, 0, 0);
    add(0, 1, 32'h80,         0, 32'h0,  0, 0, 0, 32'h80,         32'h0,  1, 1, 0, 0);
    add(0, 0, 32'h0,          0, 32'h0,  0, 0, 0, 32'h80,         32'h0,  1, 0, 0, 0);
    add(1, 1, 32'h200,        1, 32'h44, 0, 0, 0, 32'h100,        32'h44, 1, 1, 0, 0);
    add(1, 0, 32'h0,          0, 32'h0,  0, 0, 0, 32'h104,        32'h44, 1, 0, 0, 0);
    add(1, 1, 32'h300,        0, 32'h0,  1, 0, 0, 32'h44,         32'h44, 1, 1, 0, 0);
    add(0, 1, 32'hFFFF_FFFC,  0, 32'h0,  0, 0, 0, 32'hFFFF_FFFC,  32'h44, 1, 1, 0, 0);
    add(1, 0, 32'h0,          0, 32'h0,  0, 0, 0, 32'h0,          32'h44, 1, 0, 0, 0);
    add(1, 0, 32'h0,          0, 32'h0,  0, 1, 0, 32'h4,          32'h44, 0, 0, 1, 0);
    add(1, 0, 32'h0,          0, 32'h0,  0, 0, 0, 32'h4,          32'h44, 0, 0, 1, 0);
    add(1, 0, 32'h0,          0, 32'h0,  0, 1, 0, 32'h4,          32'h44, 0, 0, 1, 0);
    add(1, 0, 32'h0,          0, 32'h0,  0, 0, 1, 32'h4,          32'h44, 1, 0, 0, 0);
    add(1, 0, 32'h0,          0, 32'h0,  0, 0, 0, 32'h8,          32'h44, 1, 0, 0, 0);
    add(1, 1, 32'h400,        0, 32'h0,  0, 1, 0, 32'h400,        32'h44, 0, 1, 1, 0);
    add(0, 0, 32'h0,          1, 32'h55, 0, 0, 1, 32'h100,        32'h55, 1, 1, 0, 0);
    add(0, 0, 32'h0,          1, 32'h66, 1, 0, 0, 32'h100,        32'h66, 1, 1, 0, 0);
    add(1, 1, 32'h30,         0, 32'h0,  0, 0, 0, 32'h30,         32'h66, 1, 1, 0, 0);
    add(0, 1, 32'h82,         0, 32'h0,  0, 0, 0, MisTrap ? 32'h100 : 32'h80,
        MisTrap ? 32'h30 : 32'h66, 1, 1, 0, MisTrap);
    add(0, 0, 32'h0,          0, 32'h0,  0, 0, 0, MisTrap ? 32'h100 : 32'h80,
        MisTrap ? 32'h30 : 32'h66, 1, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_all("reset/boot", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      drive(vecs[i].rdy, vecs[i].sel, vecs[i].wb, vecs[i].trap, vecs[i].tpc, vecs[i].mret,
            vecs[i].halt, vecs[i].resume);
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].epc, vecs[i].valid, vecs[i].redir,
              vecs[i].halted, vecs[i].mis);
    end

    // Asynchronous reset mid-cycle, then a repeated BOOT cycle that ignores a branch.
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk_all("async_reset", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 rst = 1'b0;
    drive(1'b1, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_all("reboot_ignores_branch", 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_all("reboot_step", 32'h4, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Randomised traffic against the reference model.
    rst = 1'b1;
    #2 rst = 1'b0;
    model_reset();
    for (int c = 0; c < 600; c++) begin
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(0, 3) == 0) w = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, w,
            $urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 15) == 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
      model_edge();
      @(posedge clk);
      #1;
      chk_all($sformatf("rand%0d", c), m_pc, m_epc, m_mode == MRun, m_redir, m_mode == MHalt,
              m_mis);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
